// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the writeback queue entry.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order writeback FIFO: two pushes (entry_a ahead of entry_b) and one pop per edge.
// Exposes count plus per-slot valid/rd so the top can build pending flags.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     push_a,
    input  wb_entry_t                entry_a,
    input  logic                     push_b,
    input  wb_entry_t                entry_b,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [CNT_W-1:0]         count,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH*ADDR_W-1:0]  entry_rd
);

    wb_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, pos_b;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [DEPTH-1:0] valid_next;

    // entry_b lands behind entry_a only when entry_a is pushed too.
    assign pos_b       = wr_ptr + PTR_W'(push_a);
    assign wr_ptr_next = wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
    assign rd_ptr_next = rd_ptr + PTR_W'(pop);
    assign count_next  = count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    assign head        = slots[rd_ptr];

    // Clear on pop before setting on push: when full, the popped slot is refilled.
    always_comb begin
        valid_next = entry_valid;
        if (pop)    valid_next[rd_ptr] = 1'b0;
        if (push_a) valid_next[wr_ptr] = 1'b1;
        if (push_b) valid_next[pos_b]  = 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            entry_valid <= valid_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (push_a) slots[wr_ptr] <= entry_a;
        if (push_b) slots[pos_b]  <= entry_b;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign entry_rd[i*ADDR_W +: ADDR_W] = slots[i].rd;
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write front end: arbitrates ALU/load results into an in-order queue,
// drives one commit per cycle and reports pending writes for decode stalls.
module reg_writeback_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluRD,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemRD,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    output logic              RSPending,
    output logic              RTPending
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]        count, free;
    logic                    push_mem, push_alu, pop;
    wb_entry_t               head;
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH*ADDR_W-1:0] entry_rd;

    // Handshake: a result transfers on an edge where its Valid and Ready are both high;
    // Ready depends only on registered count and MemValid, never on AluValid.
    assign pop      = (count != '0);
    assign free     = CNT_W'(DEPTH) - count + CNT_W'(pop);
    assign MemReady = (free >= CNT_W'(1));
    assign AluReady = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !MemValid);
    assign push_mem = MemValid && MemReady;
    assign push_alu = AluValid && AluReady;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .push_a      (push_mem),
        .entry_a     ('{rd: MemRD, data: MemData}),
        .push_b      (push_alu),
        .entry_b     ('{rd: AluRD, data: AluData}),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // RD/WriteData only move on a commit; the register file rewrites them every edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (pop) begin
            RegWrite  <= 1'b1;
            RD        <= head.rd;
            WriteData <= head.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    always_comb begin
        RSPending = RegWrite && (RD == RS);
        RTPending = RegWrite && (RD == RT);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i*ADDR_W +: ADDR_W] == RS)) RSPending = 1'b1;
            if (entry_valid[i] && (entry_rd[i*ADDR_W +: ADDR_W] == RT)) RTPending = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a behavioural register file that
// commits WriteData to RD on every rising edge.
module tb_reg_writeback_unit;
    import cpu_pkg::*;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b1;
    logic              AluValid = 1'b0, MemValid = 1'b0;
    logic [ADDR_W-1:0] AluRD = '0, MemRD = '0, RS = '0, RT = '0;
    logic [DATA_W-1:0] AluData = '0, MemData = '0;
    logic              AluReady, MemReady, RegWrite, RSPending, RTPending;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;

    logic [DATA_W-1:0] rf [4];
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    reg_writeback_unit #(.DEPTH(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData), .MemReady(MemReady),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .RS(RS), .RT(RT), .RSPending(RSPending), .RTPending(RTPending)
    );

    always #5 Clock = ~Clock;

    initial for (int i = 0; i < 4; i++) rf[i] = '0;
    always @(posedge Clock) rf[RD] <= WriteData;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        #3 Reset_n = 1'b0;
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_cmp++; if (RD !== 2'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", RD); end
        n_cmp++; if (WriteData !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WriteData); end
        n_cmp++; if (AluReady !== 1'b1 || MemReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", AluReady, MemReady); end
        n_cmp++; if (RSPending !== 1'b0 || RTPending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got rs=%b rt=%b want 0/0", RSPending, RTPending); end
        step(); step();
        #2 Reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        RS = 2'd2; RT = 2'd3;
        AluValid = 1'b1; AluRD = 2'd2; AluData = 16'h1234;
        #1;
        n_cmp++; if (AluReady !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", AluReady); end
        step();  // E0
        AluValid = 1'b0;
        n_cmp++; if (RSPending !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_e0: got pend=%b we=%b want 1/0", RSPending, RegWrite); end
        n_cmp++; if (RTPending !== 1'b0) begin n_fail++; $display("FAIL single_rt: got %b want 0", RTPending); end
        step();  // E1
        n_cmp++; if (RegWrite !== 1'b1 || RD !== 2'd2 || WriteData !== 16'h1234) begin n_fail++; $display("FAIL single_e1: got we=%b rd=%h wd=%h want 1/2/1234", RegWrite, RD, WriteData); end
        n_cmp++; if (RSPending !== 1'b1) begin n_fail++; $display("FAIL single_pend_e1: got %b want 1", RSPending); end
        step();  // E2
        n_cmp++; if (RegWrite !== 1'b0 || RSPending !== 1'b0) begin n_fail++; $display("FAIL single_e2: got we=%b pend=%b want 0/0", RegWrite, RSPending); end
        n_cmp++; if (rf[2] !== 16'h1234) begin n_fail++; $display("FAIL single_rf: got %h want 1234", rf[2]); end
    endtask

    task automatic test_collision();
        RS = 2'd1;
        MemValid = 1'b1; MemRD = 2'd1; MemData = 16'hAAAA;
        AluValid = 1'b1; AluRD = 2'd1; AluData = 16'h5555;
        step();  // E0
        MemValid = 1'b0; AluValid = 1'b0;
        n_cmp++; if (RSPending !== 1'b1) begin n_fail++; $display("FAIL coll_pend_e0: got %b want 1", RSPending); end
        step();  // E1
        n_cmp++; if (RegWrite !== 1'b1 || RD !== 2'd1 || WriteData !== 16'hAAAA) begin n_fail++; $display("FAIL coll_first: got we=%b rd=%h wd=%h want 1/1/aaaa", RegWrite, RD, WriteData); end
        step();  // E2
        n_cmp++; if (RegWrite !== 1'b1 || RD !== 2'd1 || WriteData !== 16'h5555) begin n_fail++; $display("FAIL coll_second: got we=%b rd=%h wd=%h want 1/1/5555", RegWrite, RD, WriteData); end
        n_cmp++; if (RSPending !== 1'b1 || rf[1] !== 16'hAAAA) begin n_fail++; $display("FAIL coll_e2: got pend=%b r1=%h want 1/aaaa", RSPending, rf[1]); end
        step();  // E3
        n_cmp++; if (RSPending !== 1'b0 || rf[1] !== 16'h5555) begin n_fail++; $display("FAIL coll_e3: got pend=%b r1=%h want 0/5555", RSPending, rf[1]); end
    endtask

    task automatic test_reset_mid();
        MemValid = 1'b1; MemRD = 2'd1; MemData = 16'h1111;
        AluValid = 1'b1; AluRD = 2'd2; AluData = 16'h2222;
        step();
        MemRD = 2'd3; MemData = 16'h3333;
        AluRD = 2'd0; AluData = 16'h4444;
        step();
        MemValid = 1'b0; AluValid = 1'b0;
        RS = 2'd1; RT = 2'd3;
        n_cmp++; if (RegWrite !== 1'b1 || WriteData !== 16'h1111) begin n_fail++; $display("FAIL mid_inflight: got we=%b wd=%h want 1/1111", RegWrite, WriteData); end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++; if (RegWrite !== 1'b0 || RD !== 2'd0 || WriteData !== 16'h0) begin n_fail++; $display("FAIL mid_outputs: got we=%b rd=%h wd=%h want 0/0/0", RegWrite, RD, WriteData); end
        n_cmp++; if (RSPending !== 1'b0 || RTPending !== 1'b0) begin n_fail++; $display("FAIL mid_pending: got rs=%b rt=%b want 0/0", RSPending, RTPending); end
        #1 Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mid_no_commit: cycle %0d got %b want 0", i, RegWrite); end
        end
        n_cmp++; if (rf[0] !== 16'h0 || rf[1] !== 16'h5555 || rf[2] !== 16'h1234 || rf[3] !== 16'h0) begin
            n_fail++; $display("FAIL mid_rf: got %h %h %h %h want 0000 5555 1234 0000", rf[0], rf[1], rf[2], rf[3]);
        end
    endtask

    task automatic test_idle_hold();
        AluValid = 1'b1; AluRD = 2'd3; AluData = 16'hBEEF;
        step();
        AluValid = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (RD !== 2'd3 || WriteData !== 16'hBEEF || RegWrite !== 1'b0 || rf[3] !== 16'hBEEF) begin
                n_fail++; $display("FAIL idle_hold: cycle %0d got rd=%h wd=%h we=%b r3=%h want 3/beef/0/beef", i, RD, WriteData, RegWrite, rf[3]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int mcount = 0;
        int pre;
        int nfree;
        logic exp_alu;
        logic saw_throttle = 1'b0;
        logic [ADDR_W+DATA_W-1:0] got, want;
        for (int i = 0; i < 24; i++) begin
            MemValid = (i < 16); MemRD = ADDR_W'(i); MemData = 16'hA000 + 16'(i);
            AluValid = (i < 16); AluRD = ADDR_W'(i + 1); AluData = 16'hC000 + 16'(i);
            #3;
            nfree = 4 - mcount + ((mcount != 0) ? 1 : 0);
            exp_alu = (nfree >= 2) || (nfree >= 1 && !MemValid);
            n_cmp++; if (MemReady !== 1'b1 || AluReady !== exp_alu) begin
                n_fail++; $display("FAIL bp_ready: cycle %0d got mem=%b alu=%b want 1/%b", i, MemReady, AluReady, exp_alu);
            end
            if (AluValid && MemValid && AluReady === 1'b0) saw_throttle = 1'b1;
            pre = mcount;
            if (MemValid) begin exp_q.push_back({MemRD, MemData}); mcount++; end
            if (AluValid && exp_alu) begin exp_q.push_back({AluRD, AluData}); mcount++; end
            step();
            if (pre != 0) begin
                mcount--;
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                got = {RD, WriteData};
                n_cmp++; if (RegWrite !== 1'b1 || got !== want) begin
                    n_fail++; $display("FAIL bp_commit: cycle %0d got we=%b %h want 1 %h", i, RegWrite, got, want);
                end
            end else begin
                n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL bp_idle: cycle %0d got %b want 0", i, RegWrite); end
            end
        end
        n_cmp++; if (saw_throttle !== 1'b1) begin n_fail++; $display("FAIL bp_throttle: got %b want 1", saw_throttle); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_collision();
        test_reset_mid();
        test_idle_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Writer-side front end for the CPU's 4×16-bit register file. It accepts completed results from the ALU and the memory-load path, buffers them in a small in-order queue, and drives the register file's write port (RD, WriteData, RegWrite) with at most one commit per cycle. It also exports per-read-port pending flags so decode can stall on registers with writes still in flight.

## Interface
- DATA_W, 16, data width (matches register width)
- ADDR_W, 2, register index width (4 registers)
- DEPTH, 4, queue entries; power of two, ≥2
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- AluValid  in  1  ALU result offered
- AluRD  in  ADDR_W  ALU destination register
- AluData  in  DATA_W  ALU result
- AluReady  out  1  ALU result accepted this edge when AluValid is also high
- MemValid  in  1  load result offered
- MemRD  in  ADDR_W  load destination register
- MemData  in  DATA_W  load data
- MemReady  out  1  load result accepted this edge when MemValid is also high
- RegWrite  out  1  commit strobe to the register file
- RD  out  ADDR_W  register file write index
- WriteData  out  DATA_W  register file write data
- RS, RT  in  ADDR_W each  decode read indices being checked
- RSPending, RTPending  out  1 each  a write to RS/RT is queued or in the output stage

## Operation
- The register file commits WriteData to RD on every Clock edge, regardless of RegWrite. Therefore RD and WriteData are registered and change only on a commit. While idle they hold the last committed pair, so idle edges rewrite the same value.
- Queue: in-order FIFO, up to 2 pushes and 1 pop per edge. Count is held in a register of width clog2(DEPTH+1).
- free = DEPTH − count + (count≠0 ? 1 : 0), computed from the registered count, since a pop occurs whenever count≠0.
- MemReady = (free ≥ 1). AluReady = (free ≥ 2) or (free ≥ 1 and MemValid = 0). The memory path has priority.
- When both are accepted on the same edge, the Mem entry is pushed ahead of the Alu entry. If both target the same RD, the ALU value is the final register content.
- Output stage: on each edge with count≠0, the head entry is loaded into RD/WriteData, RegWrite is set to 1, and the entry is popped. On an edge with count = 0, RegWrite is cleared and RD/WriteData hold.
- RSPending = any valid queue entry with rd = RS, OR (RegWrite and RD = RS). RTPending is defined the same way for RT. Both are combinational.
- Only valid entries participate in pending comparison; stale slots never match.

## Timing
- Latency:
  - Result accepted at edge E0.
  - If the queue was empty, the output stage loads at E1 and RegWrite is high for the cycle E1–E2.
  - The register file commits at E2.
- Throughput: one commit per cycle. A sustained dual-source input fills the queue, after which AluReady throttles.
- Pending for a register rises combinationally in the cycle after acceptance (E0–E1) and falls after the commit edge (E2), unless another write to the same register is queued.
- Reset (Reset_n low, asynchronous): count = 0, RegWrite = 0, RD = 0, WriteData = 0. Then MemReady = 1, AluReady = 1, and both pending flags are 0.
- Reset mid-operation: all queued and output-stage writes are discarded immediately; no partial commit is issued afterward.
- Because of the every-edge commit above, register 0 receives 0 on each edge from reset until the first real commit. Registers 1–3 are unaffected.
- Count never exceeds DEPTH and never underflows. Pointers wrap modulo DEPTH.

## Structure
- Shared package cpu_pkg:
  - DATA_W and ADDR_W constants.
  - wb_entry_t struct {rd, data}.
- Sub-module wb_queue: a 2-push/1-pop FIFO of wb_entry_t. It exposes count and per-entry valid/rd vectors for the pending compare.
- The top level holds the ready logic, the output stage, and the pending comparators.

## Test plan
- Reset: assert Reset_n = 0 mid-cycle -> RegWrite = 0, RD = 0, WriteData = 0, AluReady = MemReady = 1, RSPending = RTPending = 0, all immediately.
- Single write: ALU R2 = 0x1234 accepted at E0 -> RegWrite high E1–E2 with RD = 2 and WriteData = 0x1234; R2 = 0x1234 after E2. RSPending (RS = 2) is high E0–E2.
- Same-cycle collision: Mem R1 = 0xAAAA and ALU R1 = 0x5555 at E0 -> commits R1 = 0xAAAA then R1 = 0x5555 on consecutive cycles. Final R1 = 0x5555; RSPending (RS = 1) stays high until E3.
- Backpressure:
  - Stimulus: both sources valid every cycle with distinct data.
  - Required: count saturates at 4, and AluReady is 0 whenever free = 1 with MemValid high.
  - Required: every accepted value commits exactly once, in order (Mem before Alu within an edge).
- Reset mid-operation: 3 entries queued, Reset_n pulsed low -> no further RegWrite; register contents stay as of the last completed commit, except R0 = 0.
- Idle hold: after committing R3 = 0xBEEF, 10 idle cycles -> RD = 3 and WriteData = 0xBEEF stay constant, RegWrite = 0, and R3 stays 0xBEEF.
